fetch_stage: RTL and testbench

- Instruction-fetch stage and IF/ID pipeline register of the 5-stage LEGv8 pipeline; sits directly upstream of decode.
- Holds the PC, drives the instruction-memory address, and latches the fetched word plus its PC for decode.
- Computes branch targets (B, B.cond/CBZ, BR) from the instruction held in IF/ID when decode signals a taken branch.
- Honours stall and flush requests from the hazard unit.

---
 rtl/fetch_stage_pkg.sv | 17 +
 rtl/fetch_stage_branch_target_gen.sv | 26 ++
 rtl/fetch_stage.sv | 97 +++++++++
 tb/tb_fetch_stage.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the LEGv8 fetch stage and its branch target generator.
package fetch_stage_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  localparam logic [XLEN-1:0] FETCH_RESET_PC = 64'h0;
  localparam logic [ILEN-1:0] FETCH_NOP_INSN = 32'h910003FF;

  typedef enum logic [1:0] {
    BR_COND   = 2'd0,
    BR_UNCOND = 2'd1,
    BR_REG    = 2'd2,
    BR_RSVD   = 2'd3
  } br_kind_e;

endpackage

// File: rtl/fetch_stage_branch_target_gen.sv
// Combinational branch target: sign-extended, word-scaled immediates added to the IF/ID pc, or a register target.
module branch_target_gen
  import fetch_stage_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic [25:0]     imm26,
  input  br_kind_e        kind,
  input  logic [XLEN-1:0] reg_addr,
  output logic [XLEN-1:0] target_c
);

  logic [XLEN-1:0] off19;
  logic [XLEN-1:0] off26;

  always_comb begin
    off19    = {{43{imm26[23]}}, imm26[23:5], 2'b00};
    off26    = {{36{imm26[25]}}, imm26[25:0], 2'b00};
    target_c = pc + off19;
    case (kind)
      BR_UNCOND: target_c = pc + off26;
      BR_REG:    target_c = reg_addr;
      default:   target_c = pc + off19;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// LEGv8 instruction fetch stage with IF/ID pipeline register, branch redirect, stall and flush.
// Build option FETCH_DELAY_SLOT_EN keeps the instruction fetched alongside a taken branch as a delay slot.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = FETCH_RESET_PC,
  parameter logic [ILEN-1:0] NOP_INSN = FETCH_NOP_INSN
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] imem_addr,
  input  logic [ILEN-1:0] imem_instr,
  input  logic            stall,
  input  logic            flush,
  input  logic            br_taken,
  input  logic [1:0]      br_kind,
  input  logic [XLEN-1:0] br_reg_addr,
  output logic [ILEN-1:0] if_id_instr,
  output logic [XLEN-1:0] if_id_pc,
  output logic            if_id_valid,
  output logic            misalign
);

`ifdef FETCH_DELAY_SLOT_EN
  localparam bit DELAY_SLOT = 1'b1;
`else
  localparam bit DELAY_SLOT = 1'b0;
`endif

  logic [XLEN-1:0] pc_q, pc_d;
  logic [ILEN-1:0] if_id_instr_q, if_id_instr_d;
  logic [XLEN-1:0] if_id_pc_q, if_id_pc_d;
  logic            if_id_valid_q, if_id_valid_d;
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] target_c;

  branch_target_gen u_btg (
    .pc       (if_id_pc_q),
    .imm26    (if_id_instr_q[25:0]),
    .kind     (br_kind_e'(br_kind)),
    .reg_addr (br_reg_addr),
    .target_c (target_c)
  );

  // Stall freezes everything; otherwise redirect or advance, then fill IF/ID.
  always_comb begin
    pc_d          = pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_valid_d = if_id_valid_q;
    misalign_d    = misalign_q;
    if (!stall) begin
      if (br_taken) begin
        pc_d = target_c;
        if (target_c[1:0] != 2'b00) misalign_d = 1'b1;
      end else begin
        pc_d = pc_q + 64'd4;
      end
      if (flush) begin
        if_id_instr_d = NOP_INSN;
        if_id_pc_d    = '0;
        if_id_valid_d = 1'b0;
      end else if (br_taken && !DELAY_SLOT) begin
        if_id_instr_d = NOP_INSN;
        if_id_pc_d    = pc_q;
        if_id_valid_d = 1'b0;
      end else begin
        if_id_instr_d = imem_instr;
        if_id_pc_d    = pc_q;
        if_id_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q          <= RESET_PC;
      if_id_instr_q <= NOP_INSN;
      if_id_pc_q    <= '0;
      if_id_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_valid_q <= if_id_valid_d;
      misalign_q    <= misalign_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_id_instr = if_id_instr_q;
  assign if_id_pc    = if_id_pc_q;
  assign if_id_valid = if_id_valid_q;
  assign misalign    = misalign_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, branch kinds, stall/flush priority, misalign, wrap and async reset.
module tb_fetch_stage;

  localparam logic [31:0] NOP  = 32'h910003FF;
  localparam logic [31:0] COND = 32'h54FFFFC0;
  localparam logic [31:0] UNC  = 32'h14000010;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        stall, flush, br_taken;
  logic [1:0]  br_kind;
  logic [63:0] br_reg_addr;
  logic [31:0] if_id_instr;
  logic [63:0] if_id_pc;
  logic        if_id_valid;
  logic        misalign;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_stage dut (
    .clk         (clk),
    .reset       (reset),
    .imem_addr   (imem_addr),
    .imem_instr  (imem_instr),
    .stall       (stall),
    .flush       (flush),
    .br_taken    (br_taken),
    .br_kind     (br_kind),
    .br_reg_addr (br_reg_addr),
    .if_id_instr (if_id_instr),
    .if_id_pc    (if_id_pc),
    .if_id_valid (if_id_valid),
    .misalign    (misalign)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == 64'h40)  return COND;
    if (a == 64'h100) return UNC;
    return {12'hE00, a[21:2]};
  endfunction

  always_comb imem_instr = mem_word(imem_addr);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic branch(input logic [1:0] kind, input logic [63:0] reg_addr);
    br_taken    = 1'b1;
    br_kind     = kind;
    br_reg_addr = reg_addr;
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; flush = 1'b0; br_taken = 1'b0;
    br_kind = 2'd0; br_reg_addr = '0;
    tick(); tick();
    check("rst_pc", imem_addr, 64'h0);
    check("rst_instr", 64'(if_id_instr), 64'(NOP));
    check("rst_ifpc", if_id_pc, 64'h0);
    check("rst_valid", 64'(if_id_valid), 64'd0);
    check("rst_misalign", 64'(misalign), 64'd0);
    reset = 1'b1;

    tick();
    check("run_pc4", imem_addr, 64'h4);
    check("run_ifpc0", if_id_pc, 64'h0);
    check("run_valid", 64'(if_id_valid), 64'd1);
    check("run_instr0", 64'(if_id_instr), 64'hE0000000);
    tick();
    check("run_pc8", imem_addr, 64'h8);

    // Jump to 0x40, then take the conditional branch sitting there (imm19 = -2).
    branch(2'd2, 64'h40);
    tick();
    check("br40_pc", imem_addr, 64'h40);
    br_taken = 1'b0;
    tick();
    check("cond_instr", 64'(if_id_instr), 64'(COND));
    check("cond_ifpc", if_id_pc, 64'h40);
    branch(2'd0, 64'h0);
    tick();
    check("cond_target", imem_addr, 64'h38);
`ifdef FETCH_DELAY_SLOT_EN
    check("cond_slot_valid", 64'(if_id_valid), 64'd1);
    check("cond_slot_pc", if_id_pc, 64'h44);
`else
    check("cond_slot_valid", 64'(if_id_valid), 64'd0);
    check("cond_slot_instr", 64'(if_id_instr), 64'(NOP));
`endif
    br_taken = 1'b0;
    tick();
    check("cond_target_ifpc", if_id_pc, 64'h38);
    check("cond_target_valid", 64'(if_id_valid), 64'd1);

    // Unconditional B with imm26 = 0x10 at 0x100.
    branch(2'd2, 64'h100);
    tick();
    br_taken = 1'b0;
    tick();
    check("unc_instr", 64'(if_id_instr), 64'(UNC));
    branch(2'd1, 64'h0);
    tick();
    check("unc_target", imem_addr, 64'h140);

    // Register branch.
    branch(2'd2, 64'h2000);
    tick();
    check("br_target", imem_addr, 64'h2000);
    check("br_misalign", 64'(misalign), 64'd0);
    br_taken = 1'b0;
    tick();
    check("br_ifpc", if_id_pc, 64'h2000);

    // Stall beats a pending branch.
    stall = 1'b1;
    branch(2'd2, 64'h3000);
    tick(); tick();
    check("stall_pc", imem_addr, 64'h2004);
    check("stall_ifpc", if_id_pc, 64'h2000);
    check("stall_instr", 64'(if_id_instr), 64'hE0000800);
    check("stall_valid", 64'(if_id_valid), 64'd1);
    check("stall_misalign", 64'(misalign), 64'd0);
    stall = 1'b0;
    tick();
    check("unstall_redirect", imem_addr, 64'h3000);
    br_taken = 1'b0;

    // Flush, then stall+flush where stall wins.
    flush = 1'b1;
    tick();
    check("flush_instr", 64'(if_id_instr), 64'(NOP));
    check("flush_valid", 64'(if_id_valid), 64'd0);
    check("flush_ifpc", if_id_pc, 64'h0);
    check("flush_pc", imem_addr, 64'h3004);
    flush = 1'b0;
    tick();
    stall = 1'b1; flush = 1'b1;
    tick();
    check("stallflush_valid", 64'(if_id_valid), 64'd1);
    check("stallflush_ifpc", if_id_pc, 64'h3004);
    stall = 1'b0; flush = 1'b0;

    // Misaligned register target is sticky.
    branch(2'd2, 64'h2002);
    tick();
    check("mis_pc", imem_addr, 64'h2002);
    check("mis_set", 64'(misalign), 64'd1);
    br_taken = 1'b0;
    tick(); tick();
    check("mis_sticky", 64'(misalign), 64'd1);

    // pc wrap-around.
    branch(2'd2, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    check("wrap_pre", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    br_taken = 1'b0;
    tick();
    check("wrap_pc", imem_addr, 64'h0);
    check("wrap_ifpc", if_id_pc, 64'hFFFF_FFFF_FFFF_FFFC);

    // Asynchronous reset between clock edges.
    #2;
    reset = 1'b0;
    #1;
    check("async_pc", imem_addr, 64'h0);
    check("async_misalign", 64'(misalign), 64'd0);
    check("async_valid", 64'(if_id_valid), 64'd0);
    check("async_instr", 64'(if_id_instr), 64'(NOP));
    tick();
    reset = 1'b1;
    tick();
    check("post_reset_pc", imem_addr, 64'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
